// File: rtl/i2s_slave_pkg.sv
// Shared definitions for the I2S slave: LRCK channel encodings and FSM states.
package i2s_slave_pkg;

  // LRCK level that selects each channel in standard I2S framing.
  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

  // HUNT waits for the first LRCK boundary; RUN is framed and transmitting.
  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/i2s_slave_sync_edge.sv
// Synchroniser for the asynchronous I2S pins. The bit clock and the data
// inputs travel through one shared chain, so every input sees the same
// delay. Rising and falling edges are detected on the synchronised bit
// clock.
module i2s_slave_sync_edge #(
  parameter int STAGES = 2,
  parameter int DW     = 2
) (
  input  logic          clk_in,
  input  logic          arst_in,
  input  logic          edge_in,
  input  logic [DW-1:0] data_in,
  output logic          rise_out,
  output logic          fall_out,
  output logic [DW-1:0] data_s_out
);

  // Bit DW of each stage carries the edge input; bits DW-1:0 carry the data inputs.
  logic [STAGES-1:0][DW:0] sync_q, sync_d;
  logic                    prev_q, prev_d;

  // Shift a new pin sample into stage 0. Keep the last synchronised clock level for edge detection.
  // NOTE: give every always_comb output a full assignment on every path; a missing branch infers a latch.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], {edge_in, data_in}};
    prev_d = sync_q[STAGES-1][DW];
  end

  // Synchroniser flops and the delayed copy of the synchronised clock.
  // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge arst_in) begin
    if (arst_in) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_out   =  sync_q[STAGES-1][DW] & ~prev_q;
  assign fall_out   = ~sync_q[STAGES-1][DW] &  prev_q;
  assign data_s_out =  sync_q[STAGES-1][DW-1:0];

endmodule

// File: rtl/i2s_slave.sv
// I2S slave endpoint. LRCK and SCLK come from an external master and are
// oversampled in the clk_in domain. The block deserialises sdata_in into
// MSB-aligned left/right words and serialises the parallel words onto
// sdata_out.
module i2s_slave
  import i2s_slave_pkg::*;
#(
  parameter int PDATA_WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_in,
  input  logic                   arst_in,
  input  logic                   lrck_in,
  input  logic                   sclk_in,
  input  logic                   sdata_in,
  output logic                   sdata_out,
  output logic [PDATA_WIDTH-1:0] pldata_out,
  output logic [PDATA_WIDTH-1:0] prdata_out,
  output logic                   prx_valid_out,
  input  logic [PDATA_WIDTH-1:0] pldata_in,
  input  logic [PDATA_WIDTH-1:0] prdata_in,
  output logic                   ptx_load_out
);

  localparam int W  = PDATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam int IW = $clog2(W);
  localparam logic [CW-1:0] CNT_MAX = CW'(W);

  logic       sclk_rise, sclk_fall;
  logic [1:0] sync_data;
  logic       lrck_s, sdata_s;

  i2s_slave_sync_edge #(
    .STAGES (SYNC_STAGES),
    .DW     (2)
  ) u_sync (
    .clk_in     (clk_in),
    .arst_in    (arst_in),
    .edge_in    (sclk_in),
    .data_in    ({lrck_in, sdata_in}),
    .rise_out   (sclk_rise),
    .fall_out   (sclk_fall),
    .data_s_out (sync_data)
  );

  assign lrck_s  = sync_data[1];
  assign sdata_s = sync_data[0];

  state_e          state_q, state_d;
  logic            lrck_r_q, lrck_r_d;
  logic            have_l_q, have_l_d;       // a left word started at a boundary
  logic            have_r_q, have_r_d;       // a right word followed that left word
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [W-1:0]    rx_word_q, rx_word_d;
  logic [W-1:0]    rx_stage_q, rx_stage_d;   // completed left word awaiting its right partner
  logic [W-1:0]    pldata_q, pldata_d;
  logic [W-1:0]    prdata_q, prdata_d;
  logic            prx_valid_q, prx_valid_d;
  logic [W-1:0]    tx_shift_q, tx_shift_d;
  logic [W-1:0]    tx_r_hold_q, tx_r_hold_d;
  logic            ptx_load_q, ptx_load_d;
  logic            sdata_q, sdata_d;

  logic            boundary;
  logic [W-1:0]    rx_word_w;
  logic [CW-1:0]   bit_cnt_w;
  logic [IW-1:0]   wr_idx;

  // A boundary is an SCLK rise that finds LRCK changed since the previous rise.
  assign boundary = sclk_rise && (lrck_s != lrck_r_q);
  assign wr_idx   = IW'(W - 1) - bit_cnt_q[IW-1:0];

  // Framing FSM, RX word assembly and TX shifting. All of it is qualified by synchronised SCLK edges.
  always_comb begin
    state_d     = state_q;
    lrck_r_d    = lrck_r_q;
    have_l_d    = have_l_q;
    have_r_d    = have_r_q;
    bit_cnt_d   = bit_cnt_q;
    rx_word_d   = rx_word_q;
    rx_stage_d  = rx_stage_q;
    pldata_d    = pldata_q;
    prdata_d    = prdata_q;
    prx_valid_d = 1'b0;
    tx_shift_d  = tx_shift_q;
    tx_r_hold_d = tx_r_hold_q;
    ptx_load_d  = 1'b0;
    sdata_d     = sdata_q;
    rx_word_w   = rx_word_q;
    bit_cnt_w   = bit_cnt_q;

    if (sclk_rise) begin
      lrck_r_d = lrck_s;
      // Bit k lands at position W-1-k. Bits beyond the word width are dropped.
      if (bit_cnt_q != CNT_MAX) begin
        rx_word_w[wr_idx] = sdata_s;
        bit_cnt_w         = bit_cnt_q + 1'b1;
      end
      rx_word_d = rx_word_w;
      bit_cnt_d = bit_cnt_w;

      if (boundary) begin
        // The boundary bit was the old channel's LSB. That word is complete; start a fresh one.
        state_d   = ST_RUN;
        rx_word_d = '0;
        bit_cnt_d = '0;
        if (lrck_s == LRCK_RIGHT) begin
          if (have_l_q) begin
            rx_stage_d = rx_word_w;
            have_r_d   = 1'b1;
          end
          tx_shift_d = tx_r_hold_q;
        end else if (lrck_s == LRCK_LEFT) begin
          if (have_r_q) begin
            pldata_d    = rx_stage_q;
            prdata_d    = rx_word_w;
            prx_valid_d = 1'b1;
          end
          have_l_d    = 1'b1;
          have_r_d    = 1'b0;
          tx_shift_d  = pldata_in;
          tx_r_hold_d = prdata_in;
          ptx_load_d  = 1'b1;
        end
      end
    end else if (sclk_fall && (state_q == ST_RUN)) begin
      sdata_d    = tx_shift_q[W-1];
      tx_shift_d = {tx_shift_q[W-2:0], 1'b0};
    end
  end

  // State registers. Reset aborts any frame in progress and clears all outputs.
  always_ff @(posedge clk_in or posedge arst_in) begin
    if (arst_in) begin
      state_q     <= ST_HUNT;
      lrck_r_q    <= 1'b0;
      have_l_q    <= 1'b0;
      have_r_q    <= 1'b0;
      bit_cnt_q   <= '0;
      rx_word_q   <= '0;
      rx_stage_q  <= '0;
      pldata_q    <= '0;
      prdata_q    <= '0;
      prx_valid_q <= 1'b0;
      tx_shift_q  <= '0;
      tx_r_hold_q <= '0;
      ptx_load_q  <= 1'b0;
      sdata_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lrck_r_q    <= lrck_r_d;
      have_l_q    <= have_l_d;
      have_r_q    <= have_r_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_word_q   <= rx_word_d;
      rx_stage_q  <= rx_stage_d;
      pldata_q    <= pldata_d;
      prdata_q    <= prdata_d;
      prx_valid_q <= prx_valid_d;
      tx_shift_q  <= tx_shift_d;
      tx_r_hold_q <= tx_r_hold_d;
      ptx_load_q  <= ptx_load_d;
      sdata_q     <= sdata_d;
    end
  end

  assign sdata_out     = sdata_q;
  assign pldata_out    = pldata_q;
  assign prdata_out    = prdata_q;
  assign prx_valid_out = prx_valid_q;
  assign ptx_load_out  = ptx_load_q;

endmodule

// File: tb/tb_i2s_slave.sv
// Scoreboard bench for i2s_slave. The bench models the I2S master. Each
// frame pushes its expected RX pair and TX words into queues. Separate
// monitors pop and compare whenever the DUT presents a word.
module tb_i2s_slave;

  localparam int W    = 32;
  localparam int HALF = 8;   // SCLK = clk/16

  logic          clk_in = 1'b0;
  logic          arst_in = 1'b1;
  logic          lrck_in = 1'b0;
  logic          sclk_in = 1'b1;
  logic          sdata_in = 1'b0;
  logic          sdata_out;
  logic [W-1:0]  pldata_out, prdata_out;
  logic          prx_valid_out;
  logic [W-1:0]  pldata_in = '0, prdata_in = '0;
  logic          ptx_load_out;

  i2s_slave #(.PDATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk_in        (clk_in),
    .arst_in       (arst_in),
    .lrck_in       (lrck_in),
    .sclk_in       (sclk_in),
    .sdata_in      (sdata_in),
    .sdata_out     (sdata_out),
    .pldata_out    (pldata_out),
    .prdata_out    (prdata_out),
    .prx_valid_out (prx_valid_out),
    .pldata_in     (pldata_in),
    .prdata_in     (prdata_in),
    .ptx_load_out  (ptx_load_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } rx_pair_t;

  rx_pair_t     rx_q[$];
  logic [63:0]  tx_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_frames = 0;
  int           load_cnt = 0;
  logic         prev_bit = 1'b0;
  bit           slot_chk = 1'b0;
  bit           chg_after_load = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Received word: MSB-aligned, zero-padded for short slots, truncated for long ones.
  function automatic logic [W-1:0] rx_exp(input logic [63:0] v, input int s);
    logic [63:0] t;
    if (s >= W) t = v >> (s - W);
    else        t = v << (W - s);
    return t[W-1:0];
  endfunction

  // Transmitted slot as s bits MSB first: word bits followed by zeros past W.
  function automatic logic [63:0] tx_exp(input logic [W-1:0] d, input int s);
    logic [63:0] t;
    t = {32'b0, d};
    if (s >= W) return t << (s - W);
    else        return t >> (W - s);
  endfunction

  // One SCLK period. LRCK changes at the fall. Data lags LRCK by one bit.
  task automatic step(input logic lr, input logic d);
    sclk_in  = 1'b0;
    lrck_in  = lr;
    sdata_in = prev_bit;
    prev_bit = d;
    repeat (HALF) @(negedge clk_in);
    sclk_in = 1'b1;
    repeat (HALF) @(negedge clk_in);
  endtask

  task automatic send_slot(input logic lr, input logic [63:0] v, input int s, input bit chk);
    slot_chk = chk;
    for (int k = 0; k < s; k++) step(lr, v[s-1-k]);
  endtask

  task automatic send_frame(input logic [63:0] lv, input logic [63:0] rv, input int s,
                            input logic [W-1:0] tl, input logic [W-1:0] tr, input bit chk);
    pldata_in = tl;
    prdata_in = tr;
    n_frames++;
    if (chk) begin
      rx_q.push_back({rx_exp(lv, s), rx_exp(rv, s)});
      tx_q.push_back(tx_exp(tl, s));
      tx_q.push_back(tx_exp(tr, s));
    end
    send_slot(1'b0, lv, s, chk);
    send_slot(1'b1, rv, s, chk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sdata_out"}, 64'(sdata_out), 64'h0);
    check({tag, "_pldata_out"}, 64'(pldata_out), 64'h0);
    check({tag, "_prdata_out"}, 64'(prdata_out), 64'h0);
    check({tag, "_prx_valid"}, 64'(prx_valid_out), 64'h0);
    check({tag, "_ptx_load"}, 64'(ptx_load_out), 64'h0);
  endtask

  // RX monitor: every valid pulse must match the oldest expected frame.
  always @(negedge clk_in) begin
    if (prx_valid_out) begin
      if (rx_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx_unexpected_valid: got L=%h R=%h, expected no valid", pldata_out, prdata_out);
      end else begin
        rx_pair_t e;
        e = rx_q.pop_front();
        check("rx_left", 64'(pldata_out), 64'(e.l));
        check("rx_right", 64'(prdata_out), 64'(e.r));
      end
    end
  end

  // TX monitor: the master samples sdata_out on SCLK rise. The boundary bit closes the previous slot.
  logic [63:0] mon_word = '0;
  logic        mon_lr = 1'b0;
  bit          mon_chk = 1'b0;
  always @(posedge sclk_in) begin
    if (lrck_in != mon_lr) begin
      mon_word = (mon_word << 1) | 64'(sdata_out);
      if (mon_chk) begin
        if (tx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_queue_empty: got %h, expected no checked slot", mon_word);
        end else begin
          check("tx_word", mon_word, tx_q.pop_front());
        end
      end
      mon_word = '0;
      mon_chk  = slot_chk;
      mon_lr   = lrck_in;
    end else begin
      mon_word = (mon_word << 1) | 64'(sdata_out);
    end
  end

  // Load monitor. It counts capture pulses and can disturb the parallel inputs one clock later.
  always @(negedge clk_in) begin
    if (ptx_load_out) begin
      load_cnt++;
      if (chg_after_load) begin
        @(negedge clk_in);
        pldata_in = ~pldata_in;
        prdata_in = ~prdata_in;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (5) @(negedge clk_in);
    check_all_zero("reset");
    arst_in = 1'b0;
    repeat (4) @(negedge clk_in);

    // Priming frame: the left slot has no boundary, so neither direction is checked
    send_frame(64'h11111111, 64'h22222222, 32, 32'h33333333, 32'h44444444, 1'b0);

    // 32-bit slots with exact words
    send_frame(64'hA5A50001, 64'h800000FF, 32, 32'h0F0F1234, 32'h80000001, 1'b1);
    send_frame(64'hFFFFFFFF, 64'h00000000, 32, 32'h00000000, 32'hFFFFFFFF, 1'b1);

    // 24-bit slots: LSB zero padding on RX, top 24 bits on TX
    send_frame(64'h123456, 64'hABCDEF, 24, 32'hDEADBEEF, 32'h00C0FFEE, 1'b1);

    // 40-bit slots: extra RX bits dropped, TX pads with zeros
    send_frame(64'hCAFEF00DFF, 64'h80000001AA, 40, 32'h13579BDF, 32'h2468ACE0, 1'b1);

    // Parallel inputs changed one clock after capture must not affect the frame
    chg_after_load = 1'b1;
    send_frame(64'h5A5A5A5A, 64'h3C3C3C3C, 32, 32'hFEEDFACE, 32'h01234567, 1'b1);
    send_frame(64'h0F0F0F0F, 64'hF0F0F0F0, 32, 32'h89ABCDEF, 32'h76543210, 1'b1);
    chg_after_load = 1'b0;

    // Reset pulsed mid left word: outputs clear, resync at a later boundary
    fork
      send_frame(64'h99999999, 64'h66666666, 32, 32'h55555555, 32'hAAAAAAAA, 1'b0);
      begin
        repeat (10 * 2 * HALF + 2) @(negedge clk_in);
        arst_in = 1'b1;
        @(negedge clk_in);
        check_all_zero("midreset");
        arst_in = 1'b0;
      end
    join
    send_frame(64'h00000001, 64'h80000000, 32, 32'hC3C3C3C3, 32'h3C3C3C3C, 1'b1);

    // Reset held from mid left and released mid right: no valid until a full left/right pair follows
    fork
      send_frame(64'h77777777, 64'h88888888, 32, 32'h12121212, 32'h34343434, 1'b0);
      begin
        repeat (50) @(negedge clk_in);
        arst_in = 1'b1;
        repeat (42 * 2 * HALF + 2 - 50) @(negedge clk_in);
        arst_in = 1'b0;
      end
    join
    send_frame(64'h76543210, 64'hFEDCBA98, 32, 32'hA1B2C3D4, 32'h5E6F7081, 1'b1);

    // Trailing frame whose left boundary closes the last checked frame
    send_frame(64'h0, 64'h0, 32, 32'h0, 32'h0, 1'b0);
    repeat (20) @(negedge clk_in);

    check("rx_queue_drained", 64'(rx_q.size()), 64'h0);
    check("tx_queue_drained", 64'(tx_q.size()), 64'h0);
    check("ptx_load_count", 64'(load_cnt), 64'(n_frames - 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
